mult_arbiter: RTL

- Shares one iterative shift-add multiplier between two requesters.
- Round-robin arbitration and valid/ready handshakes on request and response sides.
- Sequences the multiplier core one partial-product step per cycle.
- Returns the low WIDTH bits of the product, an overflow flag and the requester ID. Sits between lab datapath clients and the multiply resource.

---
 rtl/mult_arb_pkg.sv | 15 +
 rtl/mult_shift_add_core.sv | 61 ++++++
 rtl/mult_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types for the two-requester shift-add multiplier arbiter.
package mult_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One bit selects between the two requesters.
  typedef logic req_id_t;

endpackage

// File: rtl/mult_shift_add_core.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle
// for WIDTH cycles after start.
module mult_shift_add_core #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               run;
  logic [2*WIDTH-1:0] acc_nxt;

  // A is shifted left and B right each step, so bit 0 of b_sh is always the
  // multiplier bit for the current step.
  always_comb begin
    acc_nxt = acc;
    if (b_sh[0]) begin
      acc_nxt = acc + a_sh;
    end
  end

  // done marks the cycle in which the final step is applied; product then
  // already includes that step so the caller can capture it on the same edge.
  assign done    = run && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CNT_W'(1);
      if (done) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one shift-add multiplier between two
// requesters and returns truncated product, overflow flag and owner ID.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_id,
  output logic [WIDTH-1:0]                 rsp_result,
  output logic                             rsp_overflow,
  output logic                             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. A requester holds valid and operands stable until ready; ready
  // never depends on anything but valid, state and the priority pointer.

  state_t             state;
  state_t             state_nxt;
  req_id_t            prio;
  req_id_t            grant;
  req_id_t            owner;
  logic               accept;
  logic               core_done;
  logic [2*WIDTH-1:0] core_product;

  always_comb begin
    grant = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      grant = prio;
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && req_valid[grant]) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (core_done) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      if (accept) begin
        owner <= grant;
      end
      // Hand priority to the requester that was not just served.
      if (rsp_valid && rsp_ready) begin
        prio <= ~rsp_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else if (state == BUSY && core_done) begin
      rsp_id       <= owner;
      rsp_result   <= core_product[WIDTH-1:0];
      rsp_overflow <= |core_product[2*WIDTH-1:WIDTH];
    end
  end

  mult_shift_add_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .a       (req_a[grant]),
    .b       (req_b[grant]),
    .done    (core_done),
    .product (core_product)
  );

endmodule
